// File: rtl/snake_body_engine_if.sv
// Control/query bundle between the game controller and the snake body engine.
// master: game_state/ps2 side driving pulses and pixel-renderer queries.
// slave:  the engine, returning occupancy, head position, length and death status.
interface snake_body_engine_if #(
    parameter int XW = 6,
    parameter int YW = 6,
    parameter int LW = 5
) ();
    logic          init;       // reload initial snake, clear dead
    logic          step;       // advance one cell
    logic          dir_valid;  // dir carries a new request
    logic [1:0]    dir;        // 0=right 1=left 2=down 3=up
    logic          grow;       // lengthen on next successful step
    logic [XW-1:0] query_x;
    logic [YW-1:0] query_y;
    logic          hit;        // registered occupancy of last query
    logic [LW-1:0] hit_seg;    // lowest occupied segment index, 0 when !hit
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] length;
    logic          dead;       // latched after collision
    logic          died;       // one-cycle pulse on the collision step

    modport master (
        output init, step, dir_valid, dir, grow, query_x, query_y,
        input  hit, hit_seg, head_x, head_y, length, dead, died
    );

    modport slave (
        input  init, step, dir_valid, dir, grow, query_x, query_y,
        output hit, hit_seg, head_x, head_y, length, dead, died
    );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body state engine: segment shift register, direction latch, growth, wall/self collision, occupancy query.
// Latency: move visible one cycle after step; query hit/hit_seg one cycle after query_x/query_y.
// Backpressure: none; step/init/grow/dir_valid are single-cycle pulses always accepted.
//
// Ports: clk, rst_n (synchronous, active low), bus (slave modport of snake_body_engine_if)
//   inputs  init, step, dir_valid, dir, grow, query_x, query_y
//   outputs hit, hit_seg, head_x, head_y, length, dead, died
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    snake_body_engine_if.slave  bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [LW-1:0] length;
    logic [1:0]    cur_dir;
    logic [1:0]    pend_dir;
    logic          grow_pend;
    logic          dead;
    logic          died;
    logic          hit;
    logic [LW-1:0] hit_seg;

    // ------------------------------------------------------------------
    // Move evaluation
    // ------------------------------------------------------------------
    logic          dir_legal;
    logic [1:0]    mv_dir;
    logic          eff_grow;
    logic [XW-1:0] nh_x;
    logic [YW-1:0] nh_y;
    logic          wall_hit;
    logic          self_hit;
    logic [LW-1:0] self_lim;
    logic          collide;

    always_comb begin
        // Reversal pairs differ only in bit 0 (right/left, down/up).
        dir_legal = !((bus.dir[1] == cur_dir[1]) && (bus.dir[0] != cur_dir[0]));
        // A legal request in the step cycle applies to that very step.
        mv_dir    = (bus.dir_valid && dir_legal) ? bus.dir : pend_dir;
        eff_grow  = grow_pend | bus.grow;

        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        wall_hit = 1'b0;
        case (mv_dir)
            DIR_RIGHT: begin
                wall_hit = (seg_x[0] == XW'(GRID_W - 1));
                nh_x     = seg_x[0] + XW'(1);
            end
            DIR_LEFT: begin
                wall_hit = (seg_x[0] == '0);
                nh_x     = seg_x[0] - XW'(1);
            end
            DIR_DOWN: begin
                wall_hit = (seg_y[0] == YW'(GRID_H - 1));
                nh_y     = seg_y[0] + YW'(1);
            end
            DIR_UP: begin
                wall_hit = (seg_y[0] == '0);
                nh_y     = seg_y[0] - YW'(1);
            end
            default: ;
        endcase

        // The tail cell vacates on a normal step, so it only blocks the
        // head when the snake is about to grow. length >= 2 always.
        self_lim = eff_grow ? length : (length - LW'(1));
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < self_lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                self_hit = 1'b1;
        end

        collide = wall_hit | self_hit;
    end

    // ------------------------------------------------------------------
    // Occupancy query (registered below)
    // ------------------------------------------------------------------
    logic          q_in_grid;
    logic          q_hit;
    logic [LW-1:0] q_seg;

    always_comb begin
        q_in_grid = (int'(bus.query_x) < GRID_W) && (int'(bus.query_y) < GRID_H);
        q_hit     = 1'b0;
        q_seg     = '0;
        // Scan high to low so the lowest matching index is left standing.
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (q_in_grid && (LW'(i) < length) &&
                (seg_x[i] == bus.query_x) && (seg_y[i] == bus.query_y)) begin
                q_hit = 1'b1;
                q_seg = LW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n || bus.init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
                seg_y[i] <= '0;
            end
            length    <= LW'(INIT_LEN);
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            dead      <= 1'b0;
            died      <= 1'b0;
            hit       <= 1'b0;
            hit_seg   <= '0;
        end else begin
            hit     <= q_hit;
            hit_seg <= q_seg;
            died    <= 1'b0;

            // Direction and grow requests are latched even while dead.
            if (bus.dir_valid && dir_legal)
                pend_dir <= bus.dir;
            if (bus.grow)
                grow_pend <= 1'b1;

            if (bus.step && !dead) begin
                cur_dir <= mv_dir;
                if (collide) begin
                    dead <= 1'b1;
                    died <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nh_x;
                    seg_y[0] <= nh_y;
                    if (eff_grow) begin
                        grow_pend <= 1'b0;
                        if (length < LW'(MAX_LEN))
                            length <= length + LW'(1);
                    end
                end
            end
        end
    end

    assign bus.hit     = hit;
    assign bus.hit_seg = hit_seg;
    assign bus.head_x  = seg_x[0];
    assign bus.head_y  = seg_y[0];
    assign bus.length  = length;
    assign bus.dead    = dead;
    assign bus.died    = died;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: reset, query, direction rules,
// growth/saturation, wall and self collision, init and reset priority.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_snake_body_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    snake_body_engine_if #(.XW(6), .YW(6), .LW(5)) bus ();

    snake_body_engine #(
        .MAX_LEN(16), .INIT_LEN(4), .GRID_W(64), .GRID_H(48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(bus.head_x), 32'(x));
        chk({tag, "_y"}, 32'(bus.head_y), 32'(y));
    endtask

    task automatic query(input int x, input int y);
        bus.query_x = 6'(x);
        bus.query_y = 6'(y);
        cyc();
    endtask

    task automatic step_once();
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
    endtask

    task automatic dir_req(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir       = d;
        cyc();
        bus.dir_valid = 1'b0;
    endtask

    initial begin
        bus.init = 0; bus.step = 0; bus.dir_valid = 0; bus.dir = 0;
        bus.grow = 0; bus.query_x = 0; bus.query_y = 0;

        // 1: reset state and initial occupancy
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_length", 32'(bus.length), 4);
        chk_head("rst_head", 3, 0);
        chk("rst_dead", 32'(bus.dead), 0);
        chk("rst_died", 32'(bus.died), 0);
        query(3, 0);
        chk("q30_hit", 32'(bus.hit), 1);
        chk("q30_seg", 32'(bus.hit_seg), 0);
        query(0, 0);
        chk("q00_hit", 32'(bus.hit), 1);
        chk("q00_seg", 32'(bus.hit_seg), 3);
        query(4, 0);
        chk("q40_hit", 32'(bus.hit), 0);
        chk("q40_seg", 32'(bus.hit_seg), 0);

        // 2: reversal ignored; request in the step cycle applies to it
        dir_req(2'd1);
        step_once();
        chk_head("rev_head", 4, 0);
        bus.dir_valid = 1'b1; bus.dir = 2'd2; bus.step = 1'b1;
        cyc();
        bus.dir_valid = 1'b0; bus.step = 1'b0;
        chk_head("down_head", 4, 1);
        query(4, 0);
        chk("q_seg1_hit", 32'(bus.hit), 1);
        chk("q_seg1_seg", 32'(bus.hit_seg), 1);

        // 3: grow with step; old tail (2,0) stays occupied
        bus.grow = 1'b1; bus.step = 1'b1;
        cyc();
        bus.grow = 1'b0; bus.step = 1'b0;
        chk("grow_len", 32'(bus.length), 5);
        chk_head("grow_head", 4, 2);
        query(2, 0);
        chk("tail_hit", 32'(bus.hit), 1);
        chk("tail_seg", 32'(bus.hit_seg), 4);
        for (int i = 0; i < 11; i++) begin
            bus.grow = 1'b1; bus.step = 1'b1;
            cyc();
        end
        bus.grow = 1'b0; bus.step = 1'b0;
        chk("len_max", 32'(bus.length), 16);
        chk_head("max_head", 4, 13);
        bus.grow = 1'b1; bus.step = 1'b1;
        cyc();
        bus.grow = 1'b0; bus.step = 1'b0;
        chk("len_sat", 32'(bus.length), 16);
        chk_head("sat_head", 4, 14);

        // 4: run right into the east wall
        dir_req(2'd0);
        for (int i = 0; i < 59; i++) begin
            bus.step = 1'b1;
            cyc();
        end
        bus.step = 1'b0;
        chk_head("edge_head", 63, 14);
        chk("edge_dead", 32'(bus.dead), 0);
        step_once();
        chk("wall_died", 32'(bus.died), 1);
        chk("wall_dead", 32'(bus.dead), 1);
        chk_head("wall_head", 63, 14);
        chk("wall_len", 32'(bus.length), 16);
        cyc();
        chk("died_pulse_end", 32'(bus.died), 0);
        dir_req(2'd2);
        step_once();
        chk_head("dead_step_head", 63, 14);
        chk("dead_step_died", 32'(bus.died), 0);
        bus.init = 1'b1;
        cyc();
        bus.init = 1'b0;
        chk("init_dead", 32'(bus.dead), 0);
        chk("init_len", 32'(bus.length), 4);
        chk_head("init_head", 3, 0);

        // 5: square loop onto the vacating tail, then the same with growth
        step_once();
        dir_req(2'd2); step_once();
        dir_req(2'd1); step_once();
        dir_req(2'd3); step_once();
        chk_head("loop_head", 3, 0);
        chk("loop_dead", 32'(bus.dead), 0);
        chk("loop_died", 32'(bus.died), 0);
        bus.grow = 1'b1; bus.dir_valid = 1'b1; bus.dir = 2'd0; bus.step = 1'b1;
        cyc();
        bus.grow = 1'b0; bus.dir_valid = 1'b0; bus.step = 1'b0;
        chk("self_died", 32'(bus.died), 1);
        chk("self_dead", 32'(bus.dead), 1);
        chk_head("self_head", 3, 0);
        chk("self_len", 32'(bus.length), 4);

        // last legal request between steps wins
        bus.init = 1'b1;
        cyc();
        bus.init = 1'b0;
        dir_req(2'd3);
        dir_req(2'd2);
        dir_req(2'd1);
        step_once();
        chk_head("last_legal_head", 3, 1);

        // 6: init beats step; reset mid-run
        bus.init = 1'b1; bus.step = 1'b1;
        cyc();
        bus.init = 1'b0; bus.step = 1'b0;
        chk_head("init_step_head", 3, 0);
        chk("init_step_len", 32'(bus.length), 4);
        step_once();
        chk_head("pre_rst_head", 4, 0);
        bus.query_x = 6'd4; bus.query_y = 6'd0;
        bus.grow = 1'b1; bus.step = 1'b1;
        rst_n = 1'b0;
        cyc();
        bus.grow = 1'b0; bus.step = 1'b0;
        chk_head("mid_rst_head", 3, 0);
        chk("mid_rst_len", 32'(bus.length), 4);
        chk("mid_rst_hit", 32'(bus.hit), 0);
        chk("mid_rst_seg", 32'(bus.hit_seg), 0);
        chk("mid_rst_dead", 32'(bus.dead), 0);
        rst_n = 1'b1;
        bus.query_x = 6'd3;
        cyc();
        chk("post_rst_hit", 32'(bus.hit), 1);
        chk("post_rst_seg", 32'(bus.hit_seg), 0);
        // the step pending at reset must not survive; out-of-grid row never hits
        query(0, 50);
        chk("oob_hit", 32'(bus.hit), 0);
        chk("post_rst_len", 32'(bus.length), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
